// File: rtl/qs_pkg.sv
// ---------------------------------------------------------------------------
// qs_pkg
// Shared definitions for the quicksort engine and its AXI-Stream bridge.
//   qs_state_e      : bridge FSM state encoding
//   QS_NUM_DEFAULT  : default words per frame (equals the sorter queue depth)
// ---------------------------------------------------------------------------
package qs_pkg;

    localparam int QS_NUM_DEFAULT = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } qs_state_e;

endpackage

// File: rtl/qs_bridge_fifo.sv
// ---------------------------------------------------------------------------
// qs_bridge_fifo
// Small synchronous FIFO buffering input words ahead of the sorter.
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : asynchronous active-high reset (clears pointers only)
//   push   in  : write wdata (caller guarantees !full)
//   wdata  in  : write data
//   pop    in  : advance read pointer (caller guarantees !empty)
//   rdata  out : head of FIFO, combinational
//   full   out : no free entries
//   empty  out : no stored entries
// ---------------------------------------------------------------------------
module qs_bridge_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/qs_axis_bridge.sv
// ---------------------------------------------------------------------------
// qs_axis_bridge
// AXI-Stream wrapper around the quicksort engine. Input words are buffered
// in a FIFO, loaded QS_NUM at a time into the sorter, and the sorted words
// are drained to a registered AXI-Stream output with tlast on the final word.
// Ports:
//   clk, reset                : clock / async active-high reset
//   s_tvalid/s_tdata/s_tlast  : input stream (tlast only checked)
//   s_tready                  : input accept
//   m_tvalid/m_tdata/m_tlast  : sorted output stream
//   m_tready                  : output accept
//   qs_start                  : one-cycle sorter start pulse
//   qs_wdata                  : word to sorter (FIFO head)
//   qs_en                     : sorter data enable (load and drain)
//   qs_rdata                  : sorter result word
//   qs_dir/qs_dor/qs_idle     : sorter ready-in / result-valid / idle
//   len_err                   : sticky tlast position mismatch
//   busy                      : FSM not in IDLE
// ---------------------------------------------------------------------------
module qs_axis_bridge
    import qs_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int QS_NUM      = QS_NUM_DEFAULT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   qs_start,
    output logic [pDATA_WIDTH-1:0] qs_wdata,
    output logic                   qs_en,
    input  logic [pDATA_WIDTH-1:0] qs_rdata,
    input  logic                   qs_dir,
    input  logic                   qs_dor,
    input  logic                   qs_idle,
    output logic                   len_err,
    output logic                   busy
);

    localparam int              CW     = $clog2(QS_NUM + 1);
    localparam logic [CW-1:0]   NUM_C  = CW'(QS_NUM);
    localparam logic [CW-1:0]   LAST_C = CW'(QS_NUM - 1);

    qs_state_e               state;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [pDATA_WIDTH-1:0]  fifo_head;
    logic [CW-1:0]           in_cnt;
    logic [CW-1:0]           ld_cnt;
    logic [CW-1:0]           dr_cnt;
    logic                    load_en;
    logic                    drain_ld;

    // -------- input side: FIFO accepts in every FSM state --------
    assign s_tready  = !fifo_full & !reset;
    assign fifo_push = s_tvalid & s_tready;
    assign fifo_pop  = load_en;

    qs_bridge_fifo #(
        .DATA_W (pDATA_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (s_tdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frames are delimited by word count alone; tlast is only audited.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt  <= '0;
            len_err <= 1'b0;
        end else if (fifo_push) begin
            if (s_tlast != (in_cnt == LAST_C)) len_err <= 1'b1;
            in_cnt <= (in_cnt == LAST_C) ? '0 : in_cnt + 1'b1;
        end
    end

    // -------- sorter handshake --------
    assign load_en  = (state == ST_LOAD) & qs_dir & !fifo_empty & (ld_cnt < NUM_C);
    // The count guard keeps qs_en from firing during the extra qs_dor cycle.
    assign drain_ld = (state == ST_DRAIN) & qs_dor & (dr_cnt < NUM_C) &
                      (!m_tvalid | m_tready);
    assign qs_en    = load_en | drain_ld;
    assign qs_wdata = fifo_head;
    assign busy     = (state != ST_IDLE);

    // -------- FSM and output register stage --------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ld_cnt   <= '0;
            dr_cnt   <= '0;
            qs_start <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            qs_start <= 1'b0;
            if (load_en) ld_cnt <= ld_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_START;
                end
                ST_START: begin
                    // A previous sort may still be finishing; hold until idle.
                    if (qs_idle) begin
                        qs_start <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ld_cnt == NUM_C) begin
                        ld_cnt <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (qs_dor) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_ld) begin
                        m_tdata  <= qs_rdata;
                        m_tlast  <= (dr_cnt == LAST_C);
                        m_tvalid <= 1'b1;
                        dr_cnt   <= dr_cnt + 1'b1;
                    end else if (m_tready) begin
                        m_tvalid <= 1'b0;
                    end
                    // Leave only once the final word has actually been taken.
                    if ((dr_cnt == NUM_C) && m_tvalid && m_tready) begin
                        dr_cnt <= '0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qs_axis_bridge.sv
module tb_qs_axis_bridge;

    localparam int W  = 32;
    localparam int N  = 11;
    localparam int FD = 4;

    typedef logic [W-1:0] frame_t [N];
    typedef enum int {S_IDLE, S_LOAD, S_SORT, S_DRAIN, S_DONE, S_COOL} sst_e;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_tvalid = 1'b0;
    logic [W-1:0] s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic         m_tvalid;
    logic [W-1:0] m_tdata;
    logic         m_tlast;
    logic         m_tready = 1'b1;
    logic         qs_start;
    logic [W-1:0] qs_wdata;
    logic         qs_en;
    logic [W-1:0] qs_rdata;
    logic         qs_dir;
    logic         qs_dor;
    logic         qs_idle;
    logic         len_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qs_axis_bridge #(
        .pDATA_WIDTH (W),
        .QS_NUM      (N),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .qs_start (qs_start),
        .qs_wdata (qs_wdata),
        .qs_en    (qs_en),
        .qs_rdata (qs_rdata),
        .qs_dir   (qs_dir),
        .qs_dor   (qs_dor),
        .qs_idle  (qs_idle),
        .len_err  (len_err),
        .busy     (busy)
    );

    // ---------------- behavioural sorter ----------------
    sst_e   sst;
    int     rd, m_cnt, m_wait;
    frame_t mem, srt;
    int     start_cnt = 0, load_en_cnt = 0, drain_en_cnt = 0;
    int     viol_start = 0, viol_en = 0;
    logic [W-1:0] ld_log [$];

    function automatic frame_t sort_arr(input frame_t a);
        logic [W-1:0] t;
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a;
    endfunction

    assign qs_idle  = (sst == S_IDLE);
    assign qs_rdata = (rd < N) ? srt[rd] : 32'hDEAD_BEEF;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sst    <= S_IDLE;
            qs_dir <= 1'b0;
            qs_dor <= 1'b0;
            rd     <= 0;
            m_cnt  <= 0;
            m_wait <= 0;
        end else begin
            if (qs_start) begin
                start_cnt <= start_cnt + 1;
                if (sst != S_IDLE) viol_start <= viol_start + 1;
            end
            if (qs_en) begin
                if (sst == S_LOAD && qs_dir) begin
                    load_en_cnt <= load_en_cnt + 1;
                    ld_log.push_back(qs_wdata);
                end else if (sst == S_DRAIN) begin
                    drain_en_cnt <= drain_en_cnt + 1;
                end else begin
                    viol_en <= viol_en + 1;
                end
            end
            case (sst)
                S_IDLE: if (qs_start) begin sst <= S_LOAD; m_wait <= 2; m_cnt <= 0; end
                S_LOAD: begin
                    if (m_wait != 0) m_wait <= m_wait - 1;
                    else             qs_dir <= 1'b1;
                    if (qs_en && qs_dir) begin
                        mem[m_cnt] <= qs_wdata;
                        m_cnt      <= m_cnt + 1;
                        if (m_cnt == N - 1) begin
                            qs_dir <= 1'b0;
                            sst    <= S_SORT;
                            m_wait <= 4;
                        end
                    end
                end
                S_SORT: begin
                    if (m_wait != 0) m_wait <= m_wait - 1;
                    else begin
                        srt    <= sort_arr(mem);
                        rd     <= 0;
                        qs_dor <= 1'b1;
                        sst    <= S_DRAIN;
                    end
                end
                S_DRAIN: if (qs_en) begin
                    rd <= rd + 1;
                    if (rd == N - 1) sst <= S_DONE;
                end
                S_DONE: begin qs_dor <= 1'b0; sst <= S_COOL; m_wait <= 3; end
                default: begin
                    if (m_wait != 0) m_wait <= m_wait - 1;
                    else             sst <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------- output / event monitor ----------------
    int   cyc = 0;
    logic [W-1:0] out_data [$];
    logic         out_last [$];
    int           out_cyc  [$];
    int   full_cnt = 0, first_ld_cyc = 0, vld_rise_cyc = 0, tl_acc_cyc = 0, le_rise_cyc = 0;
    logic prev_mv = 1'b0, prev_le = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_mv <= m_tvalid;
        prev_le <= len_err;
        if (!reset) begin
            if (m_tvalid && m_tready) begin
                out_data.push_back(m_tdata);
                out_last.push_back(m_tlast);
                out_cyc.push_back(cyc);
            end
            if (s_tvalid && !s_tready) full_cnt <= full_cnt + 1;
            if (s_tvalid && s_tready && s_tlast) tl_acc_cyc <= cyc;
            if (qs_en && sst == S_DRAIN && rd == 0) first_ld_cyc <= cyc;
            if (m_tvalid && !prev_mv) vld_rise_cyc <= cyc;
            if (len_err && !prev_le) le_rise_cyc <= cyc;
        end
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    logic [W-1:0] in_data [$];
    logic         in_last [$];

    task automatic add_frame(input frame_t d, input int tl_idx);
        for (int i = 0; i < N; i++) begin
            in_data.push_back(d[i]);
            in_last.push_back(i == tl_idx);
        end
    endtask

    task automatic send_words(input bit gaps, output int timeouts);
        int g;
        timeouts = 0;
        for (int i = 0; i < in_data.size(); i++) begin
            if (gaps && (i % 3 != 0)) begin
                @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0;
                @(negedge clk);
            end
            @(negedge clk);
            s_tvalid = 1'b1; s_tdata = in_data[i]; s_tlast = in_last[i];
            #1;
            g = 0;
            while (!s_tready && g < 300) begin @(negedge clk); #1; g++; end
            if (g >= 300) timeouts++;
        end
        @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_out(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (out_data.size() >= n) break;
            @(posedge clk); #1;
        end
        ok = (out_data.size() >= n);
    endtask

    task automatic settle();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (!busy && sst == S_IDLE) break;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_m_tdata: got %0h expected 0", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast: got %b expected 0", m_tlast); end
        checks++; if (qs_start !== 1'b0) begin errors++; $display("FAIL reset_qs_start: got %b expected 0", qs_start); end
        checks++; if (qs_en !== 1'b0) begin errors++; $display("FAIL reset_qs_en: got %b expected 0", qs_en); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_s_tready: got %b expected 1", s_tready); end
        repeat (2) @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_frame();
        frame_t f;
        int base, lb, db, vs, ve, to;
        bit ok;
        base = out_data.size(); lb = load_en_cnt; db = drain_en_cnt; vs = viol_start; ve = viol_en;
        f = '{7, 3, 10, 0, 5, 9, 1, 8, 2, 6, 4};
        in_data.delete(); in_last.delete(); add_frame(f, 10);
        m_tready = 1'b1;
        send_words(1'b0, to);
        checks++; if (to != 0) begin errors++; $display("FAIL single_send: %0d timeouts, expected 0", to); end
        wait_out(base + N, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_count: got %0d words expected %0d", out_data.size() - base, N); end
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                checks++; if (out_data[base+i] !== W'(i)) begin errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, out_data[base+i], i); end
                checks++; if (out_last[base+i] !== (i == N - 1)) begin errors++; $display("FAIL single_tlast[%0d]: got %b expected %b", i, out_last[base+i], (i == N - 1)); end
            end
            checks++; if (out_cyc[base+N-1] - out_cyc[base] != N - 1) begin errors++; $display("FAIL single_throughput: span %0d cycles expected %0d", out_cyc[base+N-1] - out_cyc[base], N - 1); end
        end
        checks++; if (vld_rise_cyc - first_ld_cyc != 1) begin errors++; $display("FAIL single_latency: got %0d cycles expected 1", vld_rise_cyc - first_ld_cyc); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL single_len_err: got %b expected 0", len_err); end
        settle();
        checks++; if (load_en_cnt - lb != N) begin errors++; $display("FAIL single_load_en: got %0d expected %0d", load_en_cnt - lb, N); end
        checks++; if (drain_en_cnt - db != N) begin errors++; $display("FAIL single_drain_en: got %0d expected %0d", drain_en_cnt - db, N); end
        checks++; if (viol_en != ve || viol_start != vs) begin errors++; $display("FAIL single_protocol: got en=%0d start=%0d violations expected 0", viol_en - ve, viol_start - vs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        frame_t f;
        logic [3:0] pat;
        int base, db, ve, to;
        bit ok;
        base = out_data.size(); db = drain_en_cnt; ve = viol_en;
        pat = 4'b1001;
        f = '{50, 20, 90, 10, 70, 30, 100, 60, 40, 80, 0};
        in_data.delete(); in_last.delete(); add_frame(f, 10);
        fork
            send_words(1'b0, to);
            begin
                for (int c = 0; c < 800; c++) begin
                    @(negedge clk); m_tready = pat[c % 4];
                    if (out_data.size() >= base + N) break;
                end
                m_tready = 1'b1;
            end
        join
        wait_out(base + N, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_count: got %0d words expected %0d", out_data.size() - base, N); end
        settle();
        checks++; if (out_data.size() != base + N) begin errors++; $display("FAIL bp_total: got %0d words expected %0d", out_data.size() - base, N); end
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                checks++; if (out_data[base+i] !== W'(i * 10)) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, out_data[base+i], i * 10); end
            end
            checks++; if (out_last[base+N-1] !== 1'b1) begin errors++; $display("FAIL bp_tlast: got %b expected 1", out_last[base+N-1]); end
        end
        checks++; if (drain_en_cnt - db != N) begin errors++; $display("FAIL bp_drain_en: got %0d expected %0d", drain_en_cnt - db, N); end
        checks++; if (viol_en != ve) begin errors++; $display("FAIL bp_protocol: got %0d stray qs_en expected 0", viol_en - ve); end
    endtask

    task automatic test_input_gaps();
        frame_t f, e;
        int base, lb, li, to;
        bit ok;
        base = out_data.size(); lb = load_en_cnt; li = ld_log.size();
        f = '{15, 3, 27, 8, 1, 22, 19, 4, 30, 11, 6};
        e = '{1, 3, 4, 6, 8, 11, 15, 19, 22, 27, 30};
        in_data.delete(); in_last.delete(); add_frame(f, 10);
        m_tready = 1'b1;
        send_words(1'b1, to);
        checks++; if (to != 0) begin errors++; $display("FAIL gaps_send: %0d timeouts, expected 0", to); end
        wait_out(base + N, 1000, ok);
        settle();
        checks++; if (load_en_cnt - lb != N) begin errors++; $display("FAIL gaps_load_en: got %0d expected %0d", load_en_cnt - lb, N); end
        checks++; if (ld_log.size() - li != N) begin errors++; $display("FAIL gaps_loaded: got %0d expected %0d", ld_log.size() - li, N); end
        if (ld_log.size() - li >= N) begin
            for (int i = 0; i < N; i++) begin
                checks++; if (ld_log[li+i] !== f[i]) begin errors++; $display("FAIL gaps_load_word[%0d]: got %0d expected %0d", i, ld_log[li+i], f[i]); end
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL gaps_count: got %0d words expected %0d", out_data.size() - base, N); end
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                checks++; if (out_data[base+i] !== e[i]) begin errors++; $display("FAIL gaps_data[%0d]: got %0d expected %0d", i, out_data[base+i], e[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2;
        int base, sb, fb, vs, to;
        bit ok;
        base = out_data.size(); sb = start_cnt; fb = full_cnt; vs = viol_start;
        f1 = '{11, 1, 10, 2, 9, 3, 8, 4, 7, 5, 6};
        f2 = '{31, 30, 29, 28, 27, 26, 25, 24, 23, 22, 21};
        in_data.delete(); in_last.delete(); add_frame(f1, 10); add_frame(f2, 10);
        m_tready = 1'b1;
        send_words(1'b0, to);
        checks++; if (to != 0) begin errors++; $display("FAIL b2b_send: %0d timeouts, expected 0", to); end
        wait_out(base + 2 * N, 2000, ok);
        settle();
        checks++; if (!ok) begin errors++; $display("FAIL b2b_count: got %0d words expected %0d", out_data.size() - base, 2 * N); end
        if (ok) begin
            for (int i = 0; i < 2 * N; i++) begin
                checks++; if (out_data[base+i] !== W'((i < N) ? i + 1 : i + 10)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, out_data[base+i], (i < N) ? i + 1 : i + 10); end
                checks++; if (out_last[base+i] !== (i == N - 1 || i == 2 * N - 1)) begin errors++; $display("FAIL b2b_tlast[%0d]: got %b", i, out_last[base+i]); end
            end
        end
        checks++; if (start_cnt - sb != 2) begin errors++; $display("FAIL b2b_starts: got %0d expected 2", start_cnt - sb); end
        checks++; if (viol_start != vs) begin errors++; $display("FAIL b2b_start_while_busy: got %0d expected 0", viol_start - vs); end
        checks++; if (full_cnt - fb <= 0) begin errors++; $display("FAIL b2b_backpressure: s_tready low for %0d cycles, expected > 0", full_cnt - fb); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL b2b_len_err: got %b expected 0", len_err); end
    endtask

    task automatic test_len_err();
        frame_t f, e;
        int base, to;
        bit ok;
        base = out_data.size();
        f = '{32'hFFFF_FFFF, 32'h8000_0000, 5, 0, 3, 32'h7FFF_FFFF, 2, 1, 4, 32'h10, 8};
        e = '{0, 1, 2, 3, 4, 5, 8, 32'h10, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL lenerr_before: got %b expected 0", len_err); end
        in_data.delete(); in_last.delete(); add_frame(f, 5);
        m_tready = 1'b1;
        send_words(1'b0, to);
        wait_out(base + N, 1000, ok);
        settle();
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_sticky: got %b expected 1", len_err); end
        checks++; if (le_rise_cyc - tl_acc_cyc != 1) begin errors++; $display("FAIL lenerr_timing: got %0d cycles expected 1", le_rise_cyc - tl_acc_cyc); end
        checks++; if (!ok) begin errors++; $display("FAIL lenerr_count: got %0d words expected %0d", out_data.size() - base, N); end
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                checks++; if (out_data[base+i] !== e[i]) begin errors++; $display("FAIL lenerr_data[%0d]: got %0h expected %0h", i, out_data[base+i], e[i]); end
            end
            checks++; if (out_last[base+N-1] !== 1'b1) begin errors++; $display("FAIL lenerr_tlast: got %b expected 1", out_last[base+N-1]); end
        end
    endtask

    task automatic test_reset_mid_drain();
        frame_t f;
        int base, to;
        bit ok;
        base = out_data.size();
        f = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 10};
        in_data.delete(); in_last.delete(); add_frame(f, 10);
        m_tready = 1'b1;
        send_words(1'b0, to);
        wait_out(base + 4, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach: got %0d words expected 4", out_data.size() - base); end
        reset = 1'b1;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_m_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_mid_m_tdata: got %0h expected 0", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_mid_m_tlast: got %b expected 0", m_tlast); end
        checks++; if (qs_en !== 1'b0) begin errors++; $display("FAIL rst_mid_qs_en: got %b expected 0", qs_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_mid_s_tready: got %b expected 0", s_tready); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_mid_len_err: got %b expected 0", len_err); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_mid_release: got %b expected 1", s_tready); end
        settle();
        checks++; if (out_data.size() != base + 4) begin errors++; $display("FAIL rst_mid_leak: got %0d words expected 4", out_data.size() - base); end
        base = out_data.size();
        f = '{33, 11, 22, 55, 44, 77, 66, 99, 88, 110, 0};
        in_data.delete(); in_last.delete(); add_frame(f, 10);
        send_words(1'b0, to);
        wait_out(base + N, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_fresh_count: got %0d words expected %0d", out_data.size() - base, N); end
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                checks++; if (out_data[base+i] !== W'(i * 11)) begin errors++; $display("FAIL rst_fresh_data[%0d]: got %0d expected %0d", i, out_data[base+i], i * 11); end
            end
        end
        settle();
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_fresh_len_err: got %b expected 0", len_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_input_gaps();
        test_back_to_back();
        test_len_err();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
